// File: rtl/ln_pkg.sv
// Shared definitions for the psum local network (LN).
//   lnk()         : flat index of PE/link (row i, column j) in an array of `cols` columns
//   link_ptr_bits : pointer width for a link FIFO of a given depth ($clog2(depth))
//   STATS_W       : width of the link transfer statistics counter
package ln_pkg;

  localparam int unsigned STATS_W = 16;

  function automatic int unsigned lnk(input int unsigned i, input int unsigned j,
                                      input int unsigned cols);
    return i * cols + j;
  endfunction

  function automatic int unsigned link_ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ln_link_fifo.sv
// Single-clock link FIFO carrying psums from one PE to the PE one row below.
// Registered storage with no fall-through: a push in cycle t shows at the head in t+1.
// full/empty depend only on occupancy, so push readiness never depends on pop.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (flushes occupancy)
//   push, push_data     : write request and data; ignored while full
//   full                : occupancy == LINK_DEPTH
//   pop, head, empty    : read request, oldest entry, occupancy == 0
module ln_link_fifo
  import ln_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned LINK_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_SIZE-1:0] push_data,
  output logic                 full,
  input  logic                 pop,
  output logic [DATA_SIZE-1:0] head,
  output logic                 empty
);

  localparam int unsigned LINK_PTR_BITS = link_ptr_bits(LINK_DEPTH);
  localparam int unsigned CntW          = LINK_PTR_BITS + 1;

  logic [LINK_PTR_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]     mem_q [LINK_DEPTH];
  logic                     do_push, do_pop;

  assign full    = (cnt_q == CntW'(LINK_DEPTH));
  assign empty   = (cnt_q == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wptr_d = wptr_q + LINK_PTR_BITS'(do_push);
    rptr_d = rptr_q + LINK_PTR_BITS'(do_pop);
    cnt_d  = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is intentionally not reset; head is meaningless while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/psum_link_net.sv
// psum local network: routes each PE opsum either to the GON or through a buffered
// vertical link FIFO to the ipsum of the PE one row below (row 0 is the bottom row).
// Optional macro LN_STATS_EN: enables the saturating link transfer counter ln_xfer_cnt;
// when undefined the counter output is tied to zero.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   set_LN, LN_config_in           : load routing config (bit i: row i+1 feeds row i)
//   LN_busy                        : some link FIFO holds data
//   LN_cfg_err                     : set_LN refused because LN_busy was high
//   pe_opsum_valid/pe_opsum/ready  : PE opsum side
//   gon_ready/gon_valid            : GON handshake (GON reads data from pe_opsum)
//   gin_ipsum_valid/gin_ipsum/ready: GIN ipsum side (broadcast data)
//   pe_ipsum_valid/pe_ipsum/ready  : PE ipsum side
//   ln_xfer_cnt                    : total accepted link pushes
`ifndef NUMS_PE_ROW
`define NUMS_PE_ROW 3
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 2
`endif
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
module psum_link_net
  import ln_pkg::*;
#(
  parameter int unsigned NUMS_PE_ROW = `NUMS_PE_ROW,
  parameter int unsigned NUMS_PE_COL = `NUMS_PE_COL,
  parameter int unsigned DATA_SIZE   = `DATA_BITS,
  parameter int unsigned LINK_DEPTH  = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       set_LN,
  input  logic [NUMS_PE_ROW-2:0]                     LN_config_in,
  output logic                                       LN_busy,
  output logic                                       LN_cfg_err,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_opsum_valid,
  input  logic [DATA_SIZE*NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_opsum,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_opsum_ready,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gon_ready,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gon_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gin_ipsum_valid,
  input  logic [DATA_SIZE-1:0]                       gin_ipsum,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gin_ipsum_ready,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_ipsum_valid,
  output logic [DATA_SIZE*NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_ipsum,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_ipsum_ready,
  output logic [STATS_W-1:0]                         ln_xfer_cnt
);

  localparam int unsigned R    = NUMS_PE_ROW;
  localparam int unsigned C    = NUMS_PE_COL;
  localparam int unsigned NLnk = (R - 1) * C;

  logic [R-2:0]          cfg_q, cfg_d;
  logic [NLnk-1:0]       lnk_push, lnk_pop, lnk_full, lnk_empty;
  logic [DATA_SIZE-1:0]  lnk_head [NLnk];

  // Row 0 opsum data only ever goes to the GON, which taps the bus directly.
  logic unused_row0_opsum;
  assign unused_row0_opsum = ^pe_opsum[C*DATA_SIZE-1:0];

  // Occupancy lives in registers, so busy reflects the state after the last edge.
  assign LN_busy    = |(~lnk_empty);
  assign LN_cfg_err = set_LN && LN_busy && !rst;

  // Reconfiguration is only allowed once every link has drained.
  always_comb begin
    cfg_d = cfg_q;
    if (set_LN && !LN_busy) begin
      cfg_d = LN_config_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Link (i,j): PE (i+1,j) -> PE (i,j); link index equals the sink PE index.
  for (genvar i = 0; i < R - 1; i++) begin : g_lnk_row
    for (genvar j = 0; j < C; j++) begin : g_lnk_col
      localparam int unsigned L   = lnk(i, j, C);
      localparam int unsigned Src = lnk(i + 1, j, C);

      assign lnk_push[L] = cfg_q[i] && pe_opsum_valid[Src] && !lnk_full[L];
      assign lnk_pop[L]  = cfg_q[i] && pe_ipsum_ready[L] && !lnk_empty[L];

      ln_link_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .LINK_DEPTH(LINK_DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (lnk_push[L]),
        .push_data(pe_opsum[Src*DATA_SIZE +: DATA_SIZE]),
        .full     (lnk_full[L]),
        .pop      (lnk_pop[L]),
        .head     (lnk_head[L]),
        .empty    (lnk_empty[L])
      );
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_pe_row
    for (genvar c = 0; c < C; c++) begin : g_pe_col
      localparam int unsigned K = lnk(r, c, C);

      // Source side: rows above 0 may feed the link below instead of the GON.
      if (r >= 1) begin : g_src_lnk
        localparam int unsigned Ls = lnk(r - 1, c, C);
        assign pe_opsum_ready[K] = cfg_q[r-1] ? !lnk_full[Ls] : gon_ready[K];
        assign gon_valid[K]      = cfg_q[r-1] ? 1'b0 : pe_opsum_valid[K];
      end else begin : g_src_gon
        assign pe_opsum_ready[K] = gon_ready[K];
        assign gon_valid[K]      = pe_opsum_valid[K];
      end

      // Sink side: rows below the top may take ipsum from the link above.
      if (r <= R - 2) begin : g_snk_lnk
        assign pe_ipsum[K*DATA_SIZE +: DATA_SIZE] = cfg_q[r] ? lnk_head[K] : gin_ipsum;
        assign pe_ipsum_valid[K]  = cfg_q[r] ? !lnk_empty[K] : gin_ipsum_valid[K];
        assign gin_ipsum_ready[K] = cfg_q[r] ? 1'b0 : pe_ipsum_ready[K];
      end else begin : g_snk_gin
        assign pe_ipsum[K*DATA_SIZE +: DATA_SIZE] = gin_ipsum;
        assign pe_ipsum_valid[K]  = gin_ipsum_valid[K];
        assign gin_ipsum_ready[K] = pe_ipsum_ready[K];
      end
    end
  end

`ifdef LN_STATS_EN
  localparam int unsigned NPushW = $clog2(NLnk + 1);
  localparam int unsigned SumW   = STATS_W + 1;

  logic [STATS_W-1:0] xfer_q, xfer_d;
  logic [NPushW-1:0]  n_push;
  logic [SumW-1:0]    xfer_sum;

  // Several links can push in one cycle; add them all, then saturate.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < NLnk; k++) begin
      n_push = n_push + NPushW'(lnk_push[k]);
    end
    xfer_sum = {1'b0, xfer_q} + SumW'(n_push);
    xfer_d   = xfer_sum[STATS_W] ? '1 : xfer_sum[STATS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q <= '0;
    end else begin
      xfer_q <= xfer_d;
    end
  end

  assign ln_xfer_cnt = xfer_q;
`else
  assign ln_xfer_cnt = '0;
`endif

endmodule

// File: doc/psum_link_net.md
Name: psum_link_net

Overview:
- Parametrised successor to the combinational psum local network (LN) inside the PE array.
- Sits between the PE grid, the ipsum GIN and the opsum GON.
- Routes each PE opsum either to the GON, or through a buffered vertical link to the ipsum of the PE one row below.
- Adds per-link FIFOs, reset of the LN config, safe reconfiguration (drain check) and a busy flag.

Parameters:
- NUMS_PE_ROW, `NUMS_PE_ROW: PE rows; row 0 is the bottom row. Must be >= 2.
- NUMS_PE_COL, `NUMS_PE_COL: PE columns.
- DATA_SIZE, `DATA_BITS: psum width.
- LINK_DEPTH, 2: entries per link FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- set_LN  in  1  load LN config
- LN_config_in  in  NUMS_PE_ROW-1  bit i=1: row i+1 opsum feeds row i ipsum
- LN_busy  out  1  any link FIFO non-empty
- LN_cfg_err  out  1  one-cycle pulse: set_LN rejected
- pe_opsum_valid  in  R*C  PE opsum valid
- pe_opsum  in  DATA_SIZE*R*C  PE opsum data
- pe_opsum_ready  out  R*C  ready to PEs
- gon_ready  in  R*C  GON per-PE ready
- gon_valid  out  R*C  PE valid gated to GON (GON takes data from the pe_opsum bus)
- gin_ipsum_valid  in  R*C  GIN per-PE valid
- gin_ipsum  in  DATA_SIZE  GIN broadcast data
- gin_ipsum_ready  out  R*C  PE ready forwarded to GIN
- pe_ipsum_valid  out  R*C  ipsum valid to PEs
- pe_ipsum  out  DATA_SIZE*R*C  ipsum data to PEs
- pe_ipsum_ready  in  R*C  PE ipsum ready
- ln_xfer_cnt  out  16  link transfer count (see Optional Feature)

Behaviour:
- Indexing: PE (i,j) maps to flat index i*NUMS_PE_COL+j. Link (i,j) carries data from PE (i+1,j) to PE (i,j), for i in 0..R-2.
- Config register cfg[R-2:0]
  - Reset value 0: all rows use GIN/GON.
  - On set_LN && !LN_busy: cfg <= LN_config_in, effective the next cycle.
  - On set_LN && LN_busy: cfg unchanged; LN_cfg_err=1 for that cycle.
- Source side, row r>=1 with cfg[r-1]=1:
  - pe_opsum_ready = !full(link r-1,j); gon_valid = 0.
  - Push on pe_opsum_valid && !full.
- Source side, otherwise (incl. row 0):
  - pe_opsum_ready = gon_ready; gon_valid = pe_opsum_valid.
- Sink side, row i<=R-2 with cfg[i]=1:
  - pe_ipsum = FIFO head; pe_ipsum_valid = !empty; pop on pe_ipsum_ready && !empty.
  - gin_ipsum_ready = 0.
- Sink side, otherwise (incl. top row R-1):
  - pe_ipsum = gin_ipsum; pe_ipsum_valid = gin_ipsum_valid; gin_ipsum_ready = pe_ipsum_ready.
- Link FIFO
  - Registered, no fall-through: a push in cycle t is visible at the head in t+1. Minimum link latency 1 cycle.
  - Full/ready depend only on occupancy, so there is no combinational path from pe_ipsum_ready to pe_opsum_ready.
  - Full: push blocked even if a pop happens the same cycle.
  - Push and pop in the same cycle when non-empty and non-full: count unchanged, data order preserved.
  - Pointers wrap modulo LINK_DEPTH. Data is never dropped or duplicated.
- LN_busy: OR of !empty over all links, registered, so it reflects the state after the last edge.
- Reset mid-operation: all FIFOs flushed (count 0), cfg=0, LN_busy=0, LN_cfg_err=0, ln_xfer_cnt=0.
  - All outputs then follow the GIN/GON pass-through from the first cycle after reset.
- Data bits of the FIFO storage are not reset; pe_ipsum from an empty link is don't-care while valid=0.

Optional Feature:
- LN_STATS_EN defined: ln_xfer_cnt counts total link pushes across all links per cycle.
  - Up to (R-1)*C pushes can be added in one cycle.
  - Saturates at 16'hFFFF; cleared by rst.
- LN_STATS_EN undefined: ln_xfer_cnt tied to 0; no counter logic.

Decomposition:
- Package ln_pkg:
  - Link index function lnk(i,j).
  - LINK_PTR_BITS = $clog2(LINK_DEPTH).
  - Stats counter width constant (16).
- Sub-module ln_link_fifo: single-clock FIFO with parameters DATA_SIZE and LINK_DEPTH.
  - Ports: push/push_data/full, pop/head/empty.
  - Instantiated (R-1)*C times in a generate loop.

Test Plan (bench R=3, C=2, DATA_SIZE=32, LINK_DEPTH=2):
- Reset, all gon_ready=1, PE(2,1) opsum_valid with 0x0000_00AA -> gon_valid[5]=1, pe_opsum_ready[5]=1, pe_ipsum_valid all track gin_ipsum_valid, LN_busy=0.
- set_LN=1, LN_config_in=2'b11; PE(1,0) pushes 0x11 at t; pe_ipsum_ready[0]=0 -> pe_ipsum_valid[0]=1 from t+1 with data 0x11; LN_busy=1 from t+1; gin_ipsum_ready[0]=0.
- Same config, PE(2,1) pushes 3 values while pe_ipsum_ready[3]=0 -> two accepted, pe_opsum_ready[5]=0 on the third; release ready -> 0x1,0x2 popped in order, then third accepted.
- Link (0,1) holds 1 entry, push and pop in the same cycle for 4 cycles -> count stays 1, output sequence is the input delayed by exactly one position.
- set_LN while LN_busy=1 -> LN_cfg_err pulses 1 cycle, routing unchanged; after drain LN_busy=0, set_LN accepted, no err.
- With LN_STATS_EN: 5 pushes on link (0,0) and 3 on link (1,1), including 2 simultaneous -> ln_xfer_cnt=8. Assert rst with FIFOs non-empty -> next cycle counter=0, LN_busy=0, cfg=0.
